// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host receiver. Glitch-filters the PS/2 clock,
//               detects its falling edges and assembles 11-bit frames
//               (start, 8 data LSB first, parity, stop). The data byte is
//               presented on dout with a one-cycle done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx (
    input  logic       clk_ps2_rx,
    input  logic       reset_ps2_rx,
    input  logic       ps2d_ps2_rx,
    input  logic       ps2c_ps2_rx,
    input  logic       rx_en_ps2_rx,
    output logic       rx_done_tick_ps2_rx,
    output logic [7:0] dout_ps2_rx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DPS  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  filter_reg;
    logic [7:0]  filter_next;
    logic        f_val;
    logic        f_val_next;
    logic        fall_edge;
    logic [3:0]  n;
    logic [3:0]  n_next;
    logic [10:0] b_reg;
    logic [10:0] b_next;

    // Filter history and filtered clock level, plus FSM/datapath registers.
    always_ff @(posedge clk_ps2_rx or negedge reset_ps2_rx) begin
        if (!reset_ps2_rx) begin
            filter_reg <= 8'h00;
            f_val      <= 1'b0;
            state      <= IDLE;
            n          <= 4'd0;
            b_reg      <= 11'd0;
        end else begin
            filter_reg <= filter_next;
            f_val      <= f_val_next;
            state      <= state_next;
            n          <= n_next;
            b_reg      <= b_next;
        end
    end

    // Filtered clock only flips once 8 consecutive samples agree; the edge
    // fires in the cycle the history becomes all zero.
    always_comb begin
        filter_next = {ps2c_ps2_rx, filter_reg[7:1]};
        if (filter_next == 8'hFF)
            f_val_next = 1'b1;
        else if (filter_next == 8'h00)
            f_val_next = 1'b0;
        else
            f_val_next = f_val;
        fall_edge = f_val & ~f_val_next;
    end

    // Frame FSM: enable only gates the start bit; parity and stop are
    // shifted in but never checked.
    always_comb begin
        state_next          = state;
        n_next              = n;
        b_next              = b_reg;
        rx_done_tick_ps2_rx = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge && rx_en_ps2_rx) begin
                    b_next     = {ps2d_ps2_rx, b_reg[10:1]};
                    n_next     = 4'd9;
                    state_next = DPS;
                end
            end
            DPS: begin
                if (fall_edge) begin
                    b_next = {ps2d_ps2_rx, b_reg[10:1]};
                    if (n == 4'd0)
                        state_next = LOAD;
                    else
                        n_next = n - 4'd1;
                end
            end
            LOAD: begin
                rx_done_tick_ps2_rx = 1'b1;
                state_next          = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dout_ps2_rx = b_reg[8:1];

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx
// Description : Directed self-checking bench for ps2_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

    localparam int HALF = 30;   // PS/2 clock half-period in system clocks

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2d = 1'b0;
    logic       ps2c = 1'b0;
    logic       rx_en = 1'b1;
    logic       tick;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    int         cyc = 0;
    int         fall_cyc = 0;
    int         tick_cnt = 0;
    int         tick_lat = 0;
    int         wide_cnt = 0;
    logic       prev_tick = 1'b0;
    logic [7:0] tick_data[$];

    always #5 clk = ~clk;

    ps2_rx dut (
        .clk_ps2_rx          (clk),
        .reset_ps2_rx        (rst_n),
        .ps2d_ps2_rx         (ps2d),
        .ps2c_ps2_rx         (ps2c),
        .rx_en_ps2_rx        (rx_en),
        .rx_done_tick_ps2_rx (tick),
        .dout_ps2_rx         (dout)
    );

    // Tick monitor: counts strobes, captures data and latency, flags wide pulses.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (tick) begin
            tick_cnt = tick_cnt + 1;
            tick_lat = cyc - fall_cyc;
            tick_data.push_back(dout);
            if (prev_tick)
                wide_cnt = wide_cnt + 1;
        end
        prev_tick = tick;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int c);
        repeat (c) @(negedge clk);
    endtask

    // One PS/2 bit: high phase (optionally with a low glitch), then low phase.
    task automatic send_bit(input logic d, input int glitch);
        ps2d = d;
        ps2c = 1'b1;
        if (glitch > 0) begin
            clks(10);
            ps2c = 1'b0;
            clks(glitch);
            ps2c = 1'b1;
            clks(HALF - 10 - glitch);
        end else begin
            clks(HALF);
        end
        ps2c     = 1'b0;
        fall_cyc = cyc;
        clks(HALF);
    endtask

    // Data bits, odd parity and stop, then return the line to idle.
    task automatic send_tail(input logic [7:0] b, input int gl_bit, input int gl_len);
        for (int i = 0; i < 8; i++)
            send_bit(b[i], (gl_bit == i) ? gl_len : 0);
        send_bit(~^b, 0);
        send_bit(1'b1, 0);
        ps2d = 1'b1;
        ps2c = 1'b1;
        clks(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bit(1'b0, 0);
        send_tail(b, -1, 0);
    endtask

    int t0;
    int q0;

    initial begin
        // Reset with arbitrary inputs held low.
        clks(10);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_dout", {24'd0, dout}, 32'h00);
        ps2c = 1'b1;
        ps2d = 1'b1;
        clks(2);
        rst_n = 1'b1;
        clks(50);
        check("idle_no_tick", tick_cnt, 0);

        // Single frame 0x1C.
        t0 = tick_cnt;
        send_frame(8'h1C);
        check("f1c_ticks", tick_cnt - t0, 1);
        check("f1c_dout", {24'd0, tick_data[$]}, 32'h1C);
        check("f1c_latency", tick_lat, 8);
        clks(100);
        check("f1c_hold", {24'd0, dout}, 32'h1C);

        // Back-to-back frames.
        t0 = tick_cnt;
        q0 = tick_data.size();
        send_frame(8'hF0);
        send_frame(8'h1C);
        check("b2b_ticks", tick_cnt - t0, 2);
        check("b2b_first", {24'd0, tick_data[q0]}, 32'hF0);
        check("b2b_second", {24'd0, tick_data[q0 + 1]}, 32'h1C);

        // 5-clock glitch while ps2c high is rejected.
        t0 = tick_cnt;
        send_bit(1'b0, 0);
        send_tail(8'hA5, 3, 5);
        check("glitch5_ticks", tick_cnt - t0, 1);
        check("glitch5_dout", {24'd0, dout}, 32'hA5);

        // A 9-clock low pulse counts as an edge: here it acts as the start bit.
        t0 = tick_cnt;
        ps2d = 1'b0;
        ps2c = 1'b0;
        clks(9);
        ps2c = 1'b1;
        send_tail(8'h5A, -1, 0);
        check("glitch9_ticks", tick_cnt - t0, 1);
        check("glitch9_dout", {24'd0, dout}, 32'h5A);

        // Enable low for a whole frame: nothing received.
        t0 = tick_cnt;
        rx_en = 1'b0;
        send_frame(8'h55);
        check("en0_ticks", tick_cnt - t0, 0);
        check("en0_dout", {24'd0, dout}, 32'h5A);

        // Enable dropped after start bit: frame still completes.
        t0 = tick_cnt;
        rx_en = 1'b1;
        send_bit(1'b0, 0);
        rx_en = 1'b0;
        send_tail(8'h33, -1, 0);
        check("endrop_ticks", tick_cnt - t0, 1);
        check("endrop_dout", {24'd0, dout}, 32'h33);
        rx_en = 1'b1;

        // Reset after 5 edges discards the partial frame.
        t0 = tick_cnt;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++)
            send_bit(1'b1, 0);
        rst_n = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        clks(3);
        check("midrst_dout", {24'd0, dout}, 32'h00);
        clks(10);
        rst_n = 1'b1;
        clks(30);
        check("midrst_ticks", tick_cnt - t0, 0);
        send_frame(8'h7E);
        check("after_rst_ticks", tick_cnt - t0, 1);
        check("after_rst_dout", {24'd0, tick_data[$]}, 32'h7E);

        check("tick_width", wide_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host serial receiver. It samples the keyboard/mouse clock (ps2c) and data (ps2d) lines with the system clock and filters glitches from ps2c. It assembles each 11-bit frame (start, 8 data bits LSB first, odd parity, stop) and presents the data byte with a one-cycle done strobe. It sits between the PS/2 connector pins and the scan-code decoding logic.

## Interface
- No parameters. Filter depth is fixed at 8 samples.
- clk_ps2_rx  in  1  system clock, nominally 50–100 MHz; all logic on the rising edge.
- reset_ps2_rx  in  1  one clock; reset is asynchronous and active-low (0 = reset).
- ps2d_ps2_rx  in  1  PS/2 data line, already synchronized/pulled up externally.
- ps2c_ps2_rx  in  1  PS/2 clock line, 10–16.7 kHz, idle high.
- rx_en_ps2_rx  in  1  receive enable; gates only the start of a new frame.
- rx_done_tick_ps2_rx  out  1  one-cycle pulse when a frame completes.
- dout_ps2_rx  out  8  received data byte.

## Operation
- **Clock filter:** an 8-bit shift register samples ps2c every cycle.
  - The filtered clock f_val goes to 1 when all 8 samples are 1 and to 0 when all 8 are 0; otherwise it holds.
- **Falling edge:** fall_edge is asserted for one cycle when f_val is 1 and the next f_val is 0, i.e. the cycle in which the history becomes all-zero.
- **Data sampling:** ps2d is sampled in that same cycle.
- **Shift register:** 11-bit b_reg. On each accepted fall_edge, b_reg becomes {ps2d, b_reg[10:1]}, so the first bit ends at b_reg[0].
- **FSM states:** idle, dps (data/parity/stop), load.
  - **idle:** on fall_edge with rx_en=1, shift in the start bit, load n=9 and go to dps. A fall_edge with rx_en=0 is ignored.
  - **dps:** on each fall_edge, shift in ps2d. If n==0, go to load; else n←n−1. rx_en is ignored once the frame has started.
  - **load:** for one cycle assert rx_done_tick, then go to idle.
  - A frame therefore consumes exactly 11 falling edges.
- **Output:** dout = b_reg[8:1] (the 8 data bits).
  - dout is stable from the load cycle until the next frame's first edge.
  - dout then changes as bits shift in; consumers must latch it on the tick.
- **Parity and stop bits:** not checked. They are shifted in and discarded, and no error output exists.
- **Data line:** ps2d does not need filtering. It is stable around the ps2c falling edge per the PS/2 protocol.

## Timing
- **Reset (async, reset_ps2_rx=0):**
  - state=idle, n=0, b_reg=0, filter register=0, f_val=0.
  - rx_done_tick=0, dout=8'h00.
  - Release is synchronous to the next clock edge.
- **Edge latency:** fall_edge occurs 8 clocks after ps2c goes low and stays low.
  - ps2c low or high pulses shorter than 8 clocks do not toggle f_val.
- **Done latency:** rx_done_tick is high for exactly 1 cycle, the cycle after the 11th fall_edge (state=load).
- **Back-to-back frames:** supported. A fall_edge arriving in the load cycle is not possible at legal PS/2 rates, because edges are at least 30 µs apart.
- **After reset release:** the line idles high, so f_val reaches 1 after 8 cycles. The first real falling edge is detected only after that.
  - A ps2c held low through reset release produces no edge.
- **Reset mid-frame:** the partial frame is discarded; state returns to idle and no tick is produced.
- **No timeout:** a lost clock edge leaves the FSM in dps until reset.

## Test plan
- **Reset values:** reset_ps2_rx=0 for 100 ns with any inputs -> rx_done_tick=0, dout=8'h00; after release with ps2d=1, ps2c=1 and rx_en=1, no tick occurs.
- **Single frame 0x1C:** rx_en=1; send bits 0,0,0,1,1,1,0,0,0 then parity 0 and stop 1, with ps2c half-period 40 µs -> exactly one rx_done_tick, 1 cycle wide, 8 clocks after the 11th falling edge; dout=8'h1C, held until the next frame.
- **Back-to-back frames:** send 0xF0 then 0x1C -> two ticks, dout=8'hF0 at the first and 8'h1C at the second.
- **Glitch rejection:** during a frame of 0xA5, insert a 5-clock low glitch on ps2c while it is high -> no extra bit; dout=8'hA5. A glitch of 9 clocks is counted as an edge.
- **Enable gating:** rx_en=0, send a full 0x55 frame -> no tick and dout unchanged. rx_en dropped to 0 after the start bit of 0x33 -> frame completes and dout=8'h33.
- **Reset mid-frame:** assert reset after 5 edges -> no tick and dout=8'h00; a following complete 0x7E frame yields dout=8'h7E with one tick.
